// File: rtl/imem_stream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_stream_loader
// Description : Runtime instruction-memory loader. Receives a framed byte
//               stream (16-bit word count, little-endian payload words,
//               8-bit additive checksum), writes each assembled word into a
//               byte-enabled BRAM port and holds the hardware threads in
//               reset until a frame has loaded and passed its checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_stream_loader #(
  parameter int DWIDTH       = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int NB_COL       = 4,
  parameter int COL_WIDTH    = 8,
  parameter int MEMORY_SIZE  = 1024,
  parameter int STARTUP_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [NB_COL-1:0]     mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  err,
  input  logic                  err_clr
);

  // Byte-lane index width; a single-column memory still needs one bit.
  localparam int                    C_BIDX_W    = (NB_COL > 1) ? $clog2(NB_COL) : 1;
  localparam logic [C_BIDX_W-1:0]   C_LAST_LANE = C_BIDX_W'(NB_COL - 1);
  // Largest word count that fits between the boot address and the top of memory.
  localparam logic [31:0]           C_MAX_WORDS = 32'(MEMORY_SIZE - STARTUP_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_START     = ADDR_WIDTH'(STARTUP_ADDR);

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t                r_state,      w_state_next;
  logic [15:0]           r_cnt,        w_cnt_next;
  logic [15:0]           r_word_idx,   w_word_idx_next;
  logic [C_BIDX_W-1:0]   r_byte_idx,   w_byte_idx_next;
  logic [7:0]            r_sum,        w_sum_next;
  logic [DWIDTH-1:0]     r_asm,        w_asm_next;
  logic [NB_COL-1:0]     r_mem_we,     w_mem_we_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_next;
  logic [DWIDTH-1:0]     r_mem_wdata,  w_mem_wdata_next;
  logic                  r_s_ready;
  logic                  r_core_hold,  w_core_hold_next;
  logic                  r_done,       w_done_next;
  logic                  r_err,        w_err_next;

  logic                  w_accept;
  logic [15:0]           w_cnt_full;
  logic [15:0]           w_word_idx_inc;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [DWIDTH-1:0]     w_asm_word;

  assign w_accept       = s_valid && r_s_ready;
  assign w_cnt_full     = {s_data, r_cnt[7:0]};
  assign w_word_idx_inc = r_word_idx + 16'd1;
  assign w_word_addr    = C_START + ADDR_WIDTH'(r_word_idx);

  // Assembly register with the incoming byte dropped into its lane.
  always_comb begin
    w_asm_word = r_asm;
    w_asm_word[r_byte_idx*COL_WIDTH +: COL_WIDTH] = COL_WIDTH'(s_data);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HDR0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, datapath and output decode; outputs are derived from the
  // next state so that they appear registered one cycle after the accept.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_word_idx_next  = r_word_idx;
    w_byte_idx_next  = r_byte_idx;
    w_sum_next       = r_sum;
    w_asm_next       = r_asm;
    w_mem_we_next    = '0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;

    case (r_state)
      ST_HDR0: begin
        if (w_accept) begin
          w_cnt_next   = {r_cnt[15:8], s_data};
          w_state_next = ST_HDR1;
        end
      end

      ST_HDR1: begin
        if (w_accept) begin
          w_cnt_next      = w_cnt_full;
          w_word_idx_next = '0;
          w_byte_idx_next = '0;
          w_sum_next      = '0;
          if ({16'd0, w_cnt_full} > C_MAX_WORDS) begin
            w_state_next = ST_ERR;
          end else if (w_cnt_full == 16'd0) begin
            w_state_next = ST_CSUM;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (w_accept) begin
          w_asm_next      = w_asm_word;
          w_sum_next      = r_sum + s_data;
          w_byte_idx_next = r_byte_idx + 1'b1;
          if (r_byte_idx == C_LAST_LANE) begin
            w_mem_we_next    = '1;
            w_mem_addr_next  = w_word_addr;
            w_mem_wdata_next = w_asm_word;
            w_word_idx_next  = w_word_idx_inc;
            w_byte_idx_next  = '0;
            if (w_word_idx_inc == r_cnt) begin
              w_state_next = ST_CSUM;
            end
          end
        end
      end

      ST_CSUM: begin
        if (w_accept) begin
          w_state_next = (s_data == r_sum) ? ST_RUN : ST_ERR;
        end
      end

      ST_RUN: begin
        // A byte while running is the low count byte of a new frame.
        if (w_accept) begin
          w_cnt_next   = {r_cnt[15:8], s_data};
          w_state_next = ST_HDR1;
        end
      end

      ST_ERR: begin
        if (err_clr) begin
          w_state_next = ST_HDR0;
        end
      end

      default: begin
        w_state_next = ST_HDR0;
      end
    endcase

    w_core_hold_next = (w_state_next != ST_RUN);
    w_done_next      = (w_state_next == ST_RUN);
    w_err_next       = (w_state_next == ST_ERR);
  end

  // Datapath and output registers; a reset drops any partially assembled word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_sum       <= '0;
      r_asm       <= '0;
      r_mem_we    <= '0;
      r_mem_addr  <= C_START;
      r_mem_wdata <= '0;
      r_s_ready   <= 1'b0;
      r_core_hold <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_word_idx  <= w_word_idx_next;
      r_byte_idx  <= w_byte_idx_next;
      r_sum       <= w_sum_next;
      r_asm       <= w_asm_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_s_ready   <= 1'b1;
      r_core_hold <= w_core_hold_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
    end
  end

  assign s_ready   = r_s_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign core_hold = r_core_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_imem_stream_loader
// Description : Directed self-checking bench for imem_stream_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_stream_loader;

  localparam int ADDR_WIDTH = 10;
  localparam int NB_COL     = 4;
  localparam int DWIDTH     = 32;

  logic                  clk     = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  s_valid = 1'b0;
  logic [7:0]            s_data  = 8'h00;
  logic                  err_clr = 1'b0;
  logic                  s_ready;
  logic [NB_COL-1:0]     mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0]     mem_wdata;
  logic                  core_hold;
  logic                  done;
  logic                  err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  frame[$];
  logic [31:0] wlog_we[$];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [31:0] exp_data[$];

  imem_stream_loader #(
    .DWIDTH      (DWIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NB_COL      (NB_COL),
    .COL_WIDTH   (8),
    .MEMORY_SIZE (1024),
    .STARTUP_ADDR(0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .core_hold(core_hold),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Log every BRAM write cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we != '0) begin
      wlog_we.push_back(32'(mem_we));
      wlog_addr.push_back(32'(mem_addr));
      wlog_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wlog_we.delete();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  // Compare the write log with exp_data, words expected at addresses 0,1,2...
  task automatic check_log(input string tag);
    check({tag, "_nwrites"}, 32'(wlog_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < wlog_data.size() && i < exp_data.size(); i++) begin
      check({tag, "_we"},   wlog_we[i],   32'h0000_000F);
      check({tag, "_addr"}, wlog_addr[i], 32'(i));
      check({tag, "_data"}, wlog_data[i], exp_data[i]);
    end
  endtask

  // One byte presented for exactly one clock; returns 1ns after the edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic send_frame(input int gap_max);
    foreach (frame[i]) begin
      if (gap_max > 0) repeat (int'($urandom_range(gap_max, 0))) @(negedge clk);
      send_byte(frame[i]);
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready",   32'(s_ready),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_s_ready",   32'(s_ready),   32'd1);
    check("rel_core_hold", 32'(core_hold), 32'd1);

    // Good 2-word frame; payload sum 13+05+10+00+93+05+20+00 = 0xE0
    clear_log();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    send_frame(0);
    check("w0_we",        32'(mem_we),    32'h0000_000F);
    check("w0_addr",      32'(mem_addr),  32'd0);
    check("w0_data",      mem_wdata,      32'h0010_0513);
    check("w0_core_hold", 32'(core_hold), 32'd1);
    frame = '{8'h93, 8'h05, 8'h20, 8'h00};
    send_frame(0);
    check("w1_we",   32'(mem_we),   32'h0000_000F);
    check("w1_addr", 32'(mem_addr), 32'd1);
    check("w1_data", mem_wdata,     32'h0020_0593);
    check("pre_csum_done", 32'(done), 32'd0);
    send_byte(8'hE0);
    check("good_we_low",    32'(mem_we),    32'd0);
    check("good_done",      32'(done),      32'd1);
    check("good_core_hold", 32'(core_hold), 32'd0);
    check("good_err",       32'(err),       32'd0);
    exp_data = '{32'h0010_0513, 32'h0020_0593};
    check_log("good");

    // Zero-count frame entered from RUN
    clear_log();
    send_byte(8'h00);
    check("zero_reentry_hold", 32'(core_hold), 32'd1);
    check("zero_reentry_done", 32'(done),      32'd0);
    send_byte(8'h00);
    check("zero_hdr1_done", 32'(done), 32'd0);
    send_byte(8'h00);
    check("zero_done",      32'(done),      32'd1);
    check("zero_core_hold", 32'(core_hold), 32'd0);
    exp_data.delete();
    check_log("zero");

    // err_clr outside ERR has no effect
    pulse_err_clr();
    check("clr_in_run_done", 32'(done), 32'd1);
    check("clr_in_run_err",  32'(err),  32'd0);

    // Bad checksum: words still written, then sticky error
    clear_log();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'h15};
    send_frame(0);
    check("bad_err",       32'(err),       32'd1);
    check("bad_core_hold", 32'(core_hold), 32'd1);
    check("bad_done",      32'(done),      32'd0);
    frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(0);
    check("bad_sticky_err", 32'(err), 32'd1);
    exp_data = '{32'h0010_0513, 32'h0020_0593};
    check_log("bad");
    pulse_err_clr();
    check("bad_clr_err",  32'(err),       32'd0);
    check("bad_clr_hold", 32'(core_hold), 32'd1);
    // From HDR0 a zero-count frame takes exactly three bytes
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("after_clr_done", 32'(done), 32'd1);

    // Overflow: 0x0401 words does not fit in 1024
    clear_log();
    send_byte(8'h01);
    check("ovf_lo_err", 32'(err), 32'd0);
    send_byte(8'h04);
    check("ovf_err",  32'(err),       32'd1);
    check("ovf_hold", 32'(core_hold), 32'd1);
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    exp_data.delete();
    check_log("ovf");
    pulse_err_clr();
    check("ovf_clr_err", 32'(err), 32'd0);

    // Exactly 0x0400 words is accepted, then reset hits after 6 payload bytes
    clear_log();
    frame = '{8'h00, 8'h04, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
    send_frame(0);
    check("max_cnt_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_s_ready",   32'(s_ready),   32'd0);
    check("mid_rst_mem_we",    32'(mem_we),    32'd0);
    check("mid_rst_mem_addr",  32'(mem_addr),  32'd0);
    check("mid_rst_mem_wdata", mem_wdata,      32'd0);
    check("mid_rst_core_hold", 32'(core_hold), 32'd1);
    check("mid_rst_done",      32'(done),      32'd0);
    check("mid_rst_err",       32'(err),       32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_data = '{32'h0010_0513};
    check_log("mid_rst");

    // Fresh frame after reset loads correctly
    clear_log();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
    send_frame(0);
    check("fresh_done", 32'(done), 32'd1);
    exp_data = '{32'h0010_0513, 32'h0020_0593};
    check_log("fresh");

    // Reload from RUN with random gaps; payload sum = 0x64A -> 0x4A
    clear_log();
    send_byte(8'h03);
    check("reload_hold", 32'(core_hold), 32'd1);
    check("reload_done", 32'(done),      32'd0);
    frame = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hFF, 8'hFF, 8'h00, 8'h00};
    send_frame(3);
    check("reload_pre_csum_hold", 32'(core_hold), 32'd1);
    repeat (2) @(negedge clk);
    send_byte(8'h4A);
    check("reload_done_end", 32'(done),      32'd1);
    check("reload_hold_end", 32'(core_hold), 32'd0);
    check("reload_err_end",  32'(err),       32'd0);
    exp_data = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_FFFF};
    check_log("reload");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
